// File: rtl/uart_rx_ctrl_if.sv
// Bus/core-side signal bundle for the UART receive controller.
// master: RX core plus register interface (drives requests, reads status).
// slave:  the receive controller itself.
interface uart_rx_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
);
  localparam int AW = $clog2(DEPTH);

  // Requests from the RX core and the bus
  logic          rx_en_i;
  logic [15:0]   baud_i;
  logic          rx_done_i;
  logic [DW-1:0] rx_data_i;
  logic          rx_start_i;
  logic [AW:0]   thresh_i;
  logic [5:0]    to_bits_i;
  logic          rd_en_i;
  logic          clr_i;

  // Status and data back to the bus
  logic [DW-1:0] rd_data_o;
  logic [AW:0]   level_o;
  logic          empty_o;
  logic          full_o;
  logic          ovf_o;
  logic          timeout_o;
  logic          irq_o;

  modport master (
    output rx_en_i, baud_i, rx_done_i, rx_data_i, rx_start_i,
           thresh_i, to_bits_i, rd_en_i, clr_i,
    input  rd_data_o, level_o, empty_o, full_o, ovf_o, timeout_o, irq_o
  );

  modport slave (
    input  rx_en_i, baud_i, rx_done_i, rx_data_i, rx_start_i,
           thresh_i, to_bits_i, rd_en_i, clr_i,
    output rd_data_o, level_o, empty_o, full_o, ovf_o, timeout_o, irq_o
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: show-ahead RX FIFO, sticky overflow flag,
// character-timeout timer counted in bit periods, and a single interrupt
// combining level threshold, timeout and overflow.
module uart_rx_ctrl #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_rx_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, COUNT, FIRED} state_e;

  // FIFO storage and bookkeeping
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q;

  // Timer state
  state_e        state_q, state_d;
  logic [15:0]   clk_cnt_q, clk_cnt_d;
  logic [5:0]    bit_cnt_q, bit_cnt_d;

  logic empty, full;
  logic pop_ok, push_ok, drop;
  logic [15:0] baud_last;
  logic tick, last_tick;
  logic to_en;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LEVEL);
  assign pop_ok  = bus.rd_en_i & ~empty;
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
  assign push_ok = bus.rx_en_i & bus.rx_done_i & (~full | pop_ok);
  assign drop    = bus.rx_en_i & bus.rx_done_i & full & ~pop_ok;
  assign to_en   = (bus.to_bits_i != 6'd0);

  // Baud of 0 or 1 both mean a tick every clock
  assign baud_last = (bus.baud_i <= 16'd1) ? 16'd0 : (bus.baud_i - 16'd1);
  // >= rather than == keeps the counters bounded if baud/to_bits shrink mid-count
  assign tick      = (clk_cnt_q >= baud_last);
  assign last_tick = tick & (({1'b0, bit_cnt_q} + 7'd1) >= {1'b0, bus.to_bits_i});

  // Next FIFO occupancy from the accepted push/pop pair
  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers, level and sticky overflow; flush on clr wins over push/pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (bus.clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  // FIFO data array; contents need no reset since reads are masked when empty
  always_ff @(posedge clk_i) begin
    if (push_ok && !bus.clr_i && !rst_i) mem_q[wr_ptr_q] <= bus.rx_data_i;
  end

  // Timer state and counters register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else if (bus.clr_i) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Timer next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (push_ok && to_en) state_d = COUNT;
      end
      COUNT: begin
        if (!bus.rx_en_i || !to_en || level_d == '0) state_d = IDLE;
        else if (push_ok || bus.rx_start_i)          state_d = COUNT;
        else if (last_tick)                          state_d = FIRED;
      end
      FIRED: begin
        if (!bus.rx_en_i)  state_d = IDLE;
        else if (push_ok)  state_d = to_en ? COUNT : IDLE;
        else if (pop_ok)   state_d = (level_d != '0 && to_en) ? COUNT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters run only while staying in COUNT; any entry, restart or exit clears them
  always_comb begin
    clk_cnt_d = '0;
    bit_cnt_d = '0;
    if (state_q == COUNT && state_d == COUNT && !push_ok && !bus.rx_start_i) begin
      if (tick) begin
        clk_cnt_d = '0;
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
      end
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.timeout_o = (state_q == FIRED);
    bus.ovf_o     = ovf_q;
    bus.level_o   = level_q;
    bus.empty_o   = empty;
    bus.full_o    = full;
    bus.rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
    bus.irq_o     = ovf_q | (state_q == FIRED) |
                    ((bus.thresh_i != '0) && (level_q >= bus.thresh_i));
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART peripheral. Accepts bytes from the RX shift core and buffers them in a small FIFO for the bus. Runs a character-timeout timer in bit periods and drives one interrupt from three sources: FIFO level threshold, idle timeout and overflow. Sits between the RX core (`rx_done`/start-detect pulses) and the register interface.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2. AW = log2(DEPTH).
- DW, 8: data width.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- rx_en_i  in  1  receive enable; 0 ignores rx_done_i and holds timer in IDLE.
- baud_i  in  16  clocks per bit period; 0 or 1 means one tick per clock.
- rx_done_i  in  1  one-cycle pulse, byte valid on rx_data_i.
- rx_data_i  in  DW  received byte.
- rx_start_i  in  1  one-cycle pulse, start bit detected (line activity).
- thresh_i  in  AW+1  level interrupt threshold; 0 disables.
- to_bits_i  in  6  timeout length in bit periods; 0 disables timeout.
- rd_en_i  in  1  pop request from bus.
- clr_i  in  1  synchronous flush: FIFO, flags, timer.
- rd_data_o  out  DW  head entry (show-ahead); 0 when empty.
- level_o  out  AW+1  entries held, 0..DEPTH.
- empty_o  out  1  level_o == 0.
- full_o  out  1  level_o == DEPTH.
- ovf_o  out  1  sticky overflow flag.
- timeout_o  out  1  character timeout pending.
- irq_o  out  1  interrupt.

## Operation
- Reset: level_o 0, empty_o 1, full_o 0, ovf_o 0, timeout_o 0, irq_o 0, rd_data_o 0, pointers 0, timer IDLE, counters 0.
- Priority each cycle: rst_i > clr_i > push/pop/timer. clr_i empties the FIFO, clears ovf_o and timeout_o, and forces IDLE. A coincident push is discarded.
- Push:
  - Condition: rx_en_i & rx_done_i & (!full_o | pop accepted in the same cycle).
  - If full with no pop, the byte is dropped and ovf_o sets; the FIFO is unchanged.
- Pop:
  - Condition: rd_en_i & !empty_o.
  - rd_en_i while empty is ignored; no flag.
- Simultaneous push and pop: both occur, level unchanged. This also applies when full, where no overflow occurs.
- Pointers are AW bits and wrap modulo DEPTH. The level counter is AW+1 bits and never wraps.
- Timer FSM (states IDLE, COUNT, FIRED):
  - IDLE → COUNT on an accepted push when to_bits_i ≠ 0; clk_cnt and bit_cnt are cleared.
  - COUNT:
    - rx_start_i or an accepted push restarts both counters.
    - Otherwise clk_cnt increments. At clk_cnt == max(baud_i,1)−1, clk_cnt goes to 0 and bit_cnt increments (a tick).
    - On the tick where bit_cnt+1 == to_bits_i: → FIRED if the FIFO will be non-empty after this cycle, else → IDLE.
    - → IDLE if the FIFO becomes empty, rx_en_i = 0, or to_bits_i = 0.
  - FIRED:
    - timeout_o = 1.
    - An accepted pop → IDLE, clearing timeout_o; if the FIFO is still non-empty, go → COUNT with counters cleared instead.
    - An accepted push → COUNT with counters cleared, timeout_o cleared.
    - rx_en_i = 0 → IDLE.
  - Counter widths: clk_cnt 16 bits, bit_cnt 6 bits. Neither overflows, because the limit comparisons stop them.
- irq_o = ovf_o | timeout_o | (thresh_i ≠ 0 & level_o ≥ thresh_i).
  - Decoded from registered state only; no extra register stage.
- ovf_o clears only on clr_i or reset.

## Timing
- Push is visible in level_o, empty_o, rd_data_o (if previously empty) and irq_o the cycle after rx_done_i.
- Pop: rd_data_o is valid in the same cycle rd_en_i is asserted. The next entry appears the following cycle.
- Overflow: ovf_o and irq_o go high the cycle after the dropped rx_done_i.
- Timeout latency: with rx_done_i at cycle N and no further activity, timeout_o rises at cycle N + to_bits_i·max(baud_i,1) + 1.
- rx_start_i at cycle M restarts the count; timeout_o then rises at M + to_bits_i·max(baud_i,1) + 1 at the earliest.
- Reset asserted mid-operation: all outputs take their reset values asynchronously. The first push is accepted on the first clock after deassertion.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 → level_o 3; pops return 0x11, 0x22, 0x33 in order; empty_o 1 afterwards.
- DEPTH=8: push 9 bytes without popping → full_o 1 after the 8th push; after the 9th, ovf_o 1 and irq_o 1, and the 9th byte is absent on readback. Push and pop in the same cycle while full → level_o stays 8, ovf_o unchanged.
- thresh_i=4, to_bits_i=0: push 3 bytes → irq_o 0; the 4th push → irq_o 1 the next cycle; one pop → irq_o 0.
- baud_i=16, to_bits_i=4, thresh_i=0: one push at cycle N → timeout_o 1 at N+65, not before. A pop → timeout_o 0 the next cycle and the timer returns to IDLE.
- Same configuration with rx_start_i pulsed at N+40 → no timeout at N+65; timeout_o rises at N+40+65.
- Mid-stream: clr_i asserted together with rx_done_i → level_o 0, ovf_o 0, timeout_o 0, and the byte is discarded. rst_i pulsed while in COUNT → all outputs at reset values immediately.
